// File: rtl/strike_pkg.sv
// Shared definitions for the strike core: opcodes, FSM state encodings and
// instruction field helpers.
package strike_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_SUBI = 4'h3;
    localparam logic [3:0] OP_ANDI = 4'h4;
    localparam logic [3:0] OP_ORI  = 4'h5;
    localparam logic [3:0] OP_XORI = 4'h6;
    localparam logic [3:0] OP_OUT  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_JC   = 4'hA;
    localparam logic [3:0] OP_CALL = 4'hB;
    localparam logic [3:0] OP_RET  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hD;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    // Instruction words are widened to this size before slicing.
    localparam int WORD_MAX = 64;

    function automatic logic [3:0] op_field(input logic [WORD_MAX-1:0] word, input int addr_w);
        return word[addr_w +: 4];
    endfunction

    function automatic logic [WORD_MAX-1:0] arg_field(input logic [WORD_MAX-1:0] word, input int addr_w);
        return word & ((64'd1 << addr_w) - 64'd1);
    endfunction

endpackage

// File: rtl/strike_alu.sv
// Combinational accumulator ALU; non-ALU opcodes pass acc and carry through.
module strike_alu
    import strike_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] imm,
    input  logic              c_in,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0] sum;

    assign sum = {1'b0, acc} + {1'b0, imm};

    always_comb begin
        result = acc;
        carry  = c_in;
        case (op)
            OP_LDI:  result = imm;
            OP_ADDI: {carry, result} = sum;
            OP_SUBI: begin
                result = acc - imm;
                carry  = (acc < imm);
            end
            OP_ANDI: begin
                result = acc & imm;
                carry  = 1'b0;
            end
            OP_ORI: begin
                result = acc | imm;
                carry  = 1'b0;
            end
            OP_XORI: begin
                result = acc ^ imm;
                carry  = 1'b0;
            end
            default: ;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/strike_core.sv
// Multi-cycle fetch/execute accumulator core with flags, conditional branches,
// a return-address stack and a variable-latency ROM interface.
module strike_core
    import strike_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int ADDR_W      = 6,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [ADDR_W+3:0] rom_data,
    output logic [DATA_W-1:0] leds,
    output logic              stop,
    output logic              fault
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W+3:0] ir;
    logic [3:0]        op;
    logic [ADDR_W-1:0] arg;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] imm;
    logic              zf;
    logic              cf;
    logic [SP_W-1:0]   sp;
    logic [SP_W-1:0]   sp_dec;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  pop_idx;
    logic [ADDR_W-1:0] stack [STACK_DEPTH];
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_zero;
    logic              alu_op;

    assign op       = op_field(WORD_MAX'(ir), ADDR_W);
    assign arg      = ADDR_W'(arg_field(WORD_MAX'(ir), ADDR_W));
    assign imm      = arg[DATA_W-1:0];
    assign sp_dec   = sp - SP_W'(1);
    assign push_idx = sp[IDX_W-1:0];
    assign pop_idx  = sp_dec[IDX_W-1:0];
    assign alu_op   = (op >= OP_LDI) && (op <= OP_XORI);

    // Fetch handshake: rom_req stays high with rom_addr == pc until a cycle
    // with rom_ack high, which transfers rom_data; ack is ignored otherwise.
    assign rom_req  = (state == ST_FETCH) && !reset;
    assign rom_addr = pc;
    assign stop     = (state == ST_HALT);

    strike_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op),
        .acc    (acc),
        .imm    (imm),
        .c_in   (cf),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_FETCH;
            pc    <= '0;
            ir    <= '0;
            acc   <= '0;
            zf    <= 1'b0;
            cf    <= 1'b0;
            sp    <= '0;
            leds  <= '0;
            fault <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (rom_ack) begin
                        ir    <= rom_data;
                        pc    <= pc + ADDR_W'(1);
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state <= ST_FETCH;
                    if (alu_op) begin
                        acc <= alu_result;
                        zf  <= alu_zero;
                        cf  <= alu_carry;
                    end
                    case (op)
                        OP_OUT: leds <= acc;
                        OP_JMP: pc <= arg;
                        OP_JZ:  if (zf) pc <= arg;
                        OP_JC:  if (cf) pc <= arg;
                        OP_CALL: begin
                            if (sp == SP_FULL) begin
                                fault <= 1'b1;
                                state <= ST_HALT;
                            end else begin
                                stack[push_idx] <= pc;
                                sp              <= sp + SP_W'(1);
                                pc              <= arg;
                            end
                        end
                        OP_RET: begin
                            if (sp == '0) begin
                                fault <= 1'b1;
                                state <= ST_HALT;
                            end else begin
                                sp <= sp_dec;
                                pc <= stack[pop_idx];
                            end
                        end
                        OP_HALT: state <= ST_HALT;
                        4'hE, 4'hF: begin
                            fault <= 1'b1;
                            state <= ST_HALT;
                        end
                        default: ;
                    endcase
                end
                default: ;  // halted until reset
            endcase
        end
    end

endmodule

// File: tb/tb_strike_core.sv
// Directed bench for strike_core: program table plus timing, wrap, reset and
// wide-parameter sequences.
module tb_strike_core;
    import strike_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset = 1'b1;
    logic       rom_req, rom_ack = 1'b0, stop, fault;
    logic [5:0] rom_addr;
    logic [9:0] rom_data = '0;
    logic [3:0] leds;
    logic [9:0] rom [64];
    int         lat = 0;

    strike_core #(.DATA_W(4), .ADDR_W(6), .STACK_DEPTH(4)) dut (
        .clock(clock), .reset(reset), .rom_req(rom_req), .rom_addr(rom_addr),
        .rom_ack(rom_ack), .rom_data(rom_data), .leds(leds), .stop(stop), .fault(fault)
    );

    logic        reset8 = 1'b1;
    logic        rom_req8, rom_ack8 = 1'b0, stop8, fault8;
    logic [7:0]  rom_addr8, leds8;
    logic [11:0] rom_data8 = '0;
    logic [11:0] rom8 [256];

    strike_core #(.DATA_W(8), .ADDR_W(8), .STACK_DEPTH(2)) dut8 (
        .clock(clock), .reset(reset8), .rom_req(rom_req8), .rom_addr(rom_addr8),
        .rom_ack(rom_ack8), .rom_data(rom_data8), .leds(leds8), .stop(stop8), .fault(fault8)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ROM model for the 4/6 instance: acks after 'lat' wait cycles and checks
    // that request and address hold steady while waiting.
    int         cnt = 0;
    logic       pending = 1'b0;
    logic [5:0] wait_addr = '0;
    always @(negedge clock) begin
        if (reset) begin
            rom_ack = 1'b0;
            pending = 1'b0;
            cnt     = 0;
        end else if (pending) begin
            check("wait_req_held", 32'(rom_req), 32'd1);
            check("wait_addr_stable", 32'(rom_addr), 32'(wait_addr));
            if (cnt >= lat) begin
                rom_ack  = 1'b1;
                rom_data = rom[wait_addr];
                pending  = 1'b0;
            end else begin
                cnt++;
            end
        end else begin
            rom_ack = 1'b0;
            if (rom_req) begin
                if (lat == 0) begin
                    rom_ack  = 1'b1;
                    rom_data = rom[rom_addr];
                end else begin
                    pending   = 1'b1;
                    wait_addr = rom_addr;
                    cnt       = 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        rom_ack8  = rom_req8;
        rom_data8 = rom8[rom_addr8];
    end

    typedef struct {
        string      name;
        int         lat;
        logic [9:0] code [32];
        logic [3:0] leds;
        logic       fault;
        logic [5:0] pc;
    } vec_t;

    localparam int NV = 11;
    localparam logic [9:0] HLT = {OP_HALT, 6'h00};
    vec_t vecs [NV];

    function automatic logic [9:0] ins(input logic [3:0] op, input logic [5:0] a);
        return {op, a};
    endfunction

    function automatic void hdr(input int i, input string n, input int l,
                                input logic [3:0] ld, input logic f, input logic [5:0] p);
        vecs[i].name  = n;
        vecs[i].lat   = l;
        vecs[i].leds  = ld;
        vecs[i].fault = f;
        vecs[i].pc    = p;
    endfunction

    task automatic load_rom(input int i);
        for (int a = 0; a < 64; a++) rom[a] = (a < 32) ? vecs[i].code[a] : HLT;
        lat = vecs[i].lat;
    endtask

    task automatic run_vec(input int i);
        int cyc;
        reset = 1'b1;
        load_rom(i);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        cyc = 0;
        while (!stop && cyc < 400) begin
            @(posedge clock);
            #1 cyc++;
        end
        check($sformatf("%s_stop", vecs[i].name), 32'(stop), 32'd1);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check($sformatf("%s_leds", vecs[i].name), 32'(leds), 32'(vecs[i].leds));
        check($sformatf("%s_fault", vecs[i].name), 32'(fault), 32'(vecs[i].fault));
        check($sformatf("%s_pc", vecs[i].name), 32'(rom_addr), 32'(vecs[i].pc));
        check($sformatf("%s_req_low", vecs[i].name), 32'(rom_req), 32'd0);
        check($sformatf("%s_still_stopped", vecs[i].name), 32'(stop), 32'd1);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < NV; i++)
            for (int a = 0; a < 32; a++) vecs[i].code[a] = HLT;

        hdr(0, "zero_wait", 0, 4'h5, 1'b0, 6'h03);
        vecs[0].code[0] = ins(OP_LDI, 6'h05);
        vecs[0].code[1] = ins(OP_OUT, 6'h00);
        hdr(1, "wait3", 3, 4'h5, 1'b0, 6'h03);
        vecs[1].code = vecs[0].code;
        hdr(2, "carry_jc", 0, 4'hA, 1'b0, 6'h13);
        vecs[2].code[0]  = ins(OP_LDI, 6'h0F);
        vecs[2].code[1]  = ins(OP_ADDI, 6'h01);
        vecs[2].code[2]  = ins(OP_JC, 6'h10);
        vecs[2].code[3]  = ins(OP_OUT, 6'h00);
        vecs[2].code[16] = ins(OP_LDI, 6'h0A);
        vecs[2].code[17] = ins(OP_OUT, 6'h00);
        hdr(3, "zero_jz", 2, 4'h6, 1'b0, 6'h13);
        vecs[3].code[0]  = ins(OP_LDI, 6'h0F);
        vecs[3].code[1]  = ins(OP_ADDI, 6'h01);
        vecs[3].code[2]  = ins(OP_JZ, 6'h10);
        vecs[3].code[3]  = ins(OP_LDI, 6'h03);
        vecs[3].code[4]  = ins(OP_OUT, 6'h00);
        vecs[3].code[16] = ins(OP_ORI, 6'h06);
        vecs[3].code[17] = ins(OP_OUT, 6'h00);
        hdr(4, "subi_borrow", 1, 4'h7, 1'b0, 6'h13);
        vecs[4].code[0]  = ins(OP_LDI, 6'h02);
        vecs[4].code[1]  = ins(OP_SUBI, 6'h03);
        vecs[4].code[2]  = ins(OP_JC, 6'h10);
        vecs[4].code[16] = ins(OP_ANDI, 6'h07);
        vecs[4].code[17] = ins(OP_OUT, 6'h00);
        hdr(5, "jc_not_taken", 0, 4'h2, 1'b0, 6'h05);
        vecs[5].code[0]  = ins(OP_LDI, 6'h01);
        vecs[5].code[1]  = ins(OP_ADDI, 6'h01);
        vecs[5].code[2]  = ins(OP_JC, 6'h10);
        vecs[5].code[3]  = ins(OP_OUT, 6'h00);
        vecs[5].code[16] = ins(OP_LDI, 6'h09);
        vecs[5].code[17] = ins(OP_OUT, 6'h00);
        hdr(6, "call_depth4", 1, 4'h8, 1'b0, 6'h03);
        vecs[6].code[0]  = ins(OP_CALL, 6'h10);
        vecs[6].code[1]  = ins(OP_OUT, 6'h00);
        vecs[6].code[16] = ins(OP_CALL, 6'h13);
        vecs[6].code[17] = ins(OP_ADDI, 6'h01);
        vecs[6].code[18] = ins(OP_RET, 6'h00);
        vecs[6].code[19] = ins(OP_CALL, 6'h16);
        vecs[6].code[20] = ins(OP_ORI, 6'h04);
        vecs[6].code[21] = ins(OP_RET, 6'h00);
        vecs[6].code[22] = ins(OP_CALL, 6'h19);
        vecs[6].code[23] = ins(OP_ORI, 6'h02);
        vecs[6].code[24] = ins(OP_RET, 6'h00);
        vecs[6].code[25] = ins(OP_LDI, 6'h01);
        vecs[6].code[26] = ins(OP_RET, 6'h00);
        hdr(7, "call_overflow", 0, 4'h3, 1'b1, 6'h14);
        vecs[7].code[0]  = ins(OP_LDI, 6'h03);
        vecs[7].code[1]  = ins(OP_OUT, 6'h00);
        vecs[7].code[2]  = ins(OP_CALL, 6'h10);
        vecs[7].code[16] = ins(OP_CALL, 6'h11);
        vecs[7].code[17] = ins(OP_CALL, 6'h12);
        vecs[7].code[18] = ins(OP_CALL, 6'h13);
        vecs[7].code[19] = ins(OP_CALL, 6'h14);
        hdr(8, "ret_empty", 0, 4'h0, 1'b1, 6'h01);
        vecs[8].code[0] = ins(OP_RET, 6'h00);
        hdr(9, "illegal_e", 0, 4'h6, 1'b1, 6'h03);
        vecs[9].code[0] = ins(OP_LDI, 6'h06);
        vecs[9].code[1] = ins(OP_OUT, 6'h00);
        vecs[9].code[2] = ins(4'hE, 6'h00);
        hdr(10, "illegal_f", 2, 4'h9, 1'b1, 6'h04);
        vecs[10].code[0] = ins(OP_LDI, 6'h05);
        vecs[10].code[1] = ins(OP_XORI, 6'h0C);
        vecs[10].code[2] = ins(OP_OUT, 6'h00);
        vecs[10].code[3] = ins(4'hF, 6'h00);

        for (int i = 0; i < NV; i++) run_vec(i);

        // Reset while halted with a fault clears everything on the next edge.
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("halt_reset_stop", 32'(stop), 32'd0);
        check("halt_reset_fault", 32'(fault), 32'd0);
        check("halt_reset_leds", 32'(leds), 32'd0);
        check("halt_reset_req", 32'(rom_req), 32'd0);

        // Cycle-exact zero-wait timing of LDI 5; OUT; HALT.
        load_rom(0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("first_req", 32'(rom_req), 32'd1);
        check("first_addr", 32'(rom_addr), 32'd0);
        repeat (3) @(posedge clock);
        #1 check("leds_cycle3", 32'(leds), 32'h0);
        @(posedge clock);
        #1 check("leds_cycle4", 32'(leds), 32'h5);
        @(posedge clock);
        #1 check("stop_cycle5", 32'(stop), 32'd0);
        @(posedge clock);
        #1 check("stop_cycle6", 32'(stop), 32'd1);
        check("fault_cycle6", 32'(fault), 32'd0);

        // PC wrap: NOP at 0x3F is followed by a fetch from 0x00.
        reset = 1'b1;
        for (int a = 0; a < 64; a++) rom[a] = HLT;
        rom[0]  = ins(OP_JMP, 6'h3F);
        rom[63] = ins(OP_NOP, 6'h00);
        lat = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("wrap_pre_addr", 32'(rom_addr), 32'h3F);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("wrap_addr", 32'(rom_addr), 32'h00);
        check("wrap_req", 32'(rom_req), 32'd1);

        // Reset during a slow pending fetch.
        reset = 1'b1;
        for (int a = 0; a < 64; a++) rom[a] = ins(OP_NOP, 6'h00);
        rom[0] = ins(OP_LDI, 6'h07);
        rom[1] = ins(OP_OUT, 6'h00);
        lat = 1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        cyc = 0;
        while (leds != 4'h7 && cyc < 100) begin
            @(posedge clock);
            #1 cyc++;
        end
        check("pend_leds", 32'(leds), 32'h7);
        lat = 10;
        @(negedge clock);
        @(negedge clock);
        check("pend_req", 32'(rom_req), 32'd1);
        check("pend_addr", 32'(rom_addr), 32'h02);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midfetch_leds", 32'(leds), 32'h0);
        check("midfetch_req", 32'(rom_req), 32'd0);
        check("midfetch_addr", 32'(rom_addr), 32'h00);
        check("midfetch_stop", 32'(stop), 32'd0);
        check("midfetch_fault", 32'(fault), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("restart_req", 32'(rom_req), 32'd1);
        check("restart_addr", 32'(rom_addr), 32'h00);
        lat = 0;

        // Wide instance: 0xFF + 0x01 wraps to 0 with carry set.
        for (int a = 0; a < 256; a++) rom8[a] = {OP_HALT, 8'h00};
        rom8[0]     = {OP_LDI, 8'hFF};
        rom8[1]     = {OP_ADDI, 8'h01};
        rom8[2]     = {OP_JC, 8'h10};
        rom8[3]     = {OP_OUT, 8'h00};
        rom8[8'h10] = {OP_ORI, 8'hA5};
        rom8[8'h11] = {OP_OUT, 8'h00};
        reset8 = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset8 = 1'b0;
        cyc = 0;
        while (!stop8 && cyc < 100) begin
            @(posedge clock);
            #1 cyc++;
        end
        check("w8_stop", 32'(stop8), 32'd1);
        check("w8_leds", 32'(leds8), 32'hA5);
        check("w8_fault", 32'(fault8), 32'd0);
        check("w8_pc", 32'(rom_addr8), 32'h13);

        // Wide instance: third nested CALL overflows a 2-entry stack.
        reset8 = 1'b1;
        for (int a = 0; a < 256; a++) rom8[a] = {OP_HALT, 8'h00};
        rom8[0]     = {OP_CALL, 8'h40};
        rom8[8'h40] = {OP_CALL, 8'h41};
        rom8[8'h41] = {OP_CALL, 8'h42};
        repeat (2) @(posedge clock);
        #1 reset8 = 1'b0;
        cyc = 0;
        while (!stop8 && cyc < 100) begin
            @(posedge clock);
            #1 cyc++;
        end
        check("w8_ovf_stop", 32'(stop8), 32'd1);
        check("w8_ovf_fault", 32'(fault8), 32'd1);
        check("w8_ovf_pc", 32'(rom_addr8), 32'h42);
        check("w8_ovf_leds", 32'(leds8), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/strike_core.md
Name: strike_core

Overview:
- Parametrised next-generation strike processor core: multi-cycle fetch/execute accumulator machine with configurable data width, address width and call-stack depth.
- Adds conditional branches, carry/zero flags, CALL/RET and a ROM request/acknowledge handshake, so program memory may have variable latency.
- Sits between the program ROM (external) and the board LEDs/stop indicator.

Parameters:
- DATA_W, 4, accumulator/LED width; 1..ADDR_W.
- ADDR_W, 6, program counter / ROM address width; also the operand field width.
- STACK_DEPTH, 4, return-address stack entries; minimum 1.

Ports:
- clock  in  1  system clock, all state on the rising edge.
- reset  in  1  synchronous, active-high.
- rom_req  out  1  fetch request, held high until acknowledged.
- rom_addr  out  ADDR_W  fetch address, equal to pc while rom_req is high.
- rom_ack  in  1  ROM data valid this cycle; ignored when rom_req is low.
- rom_data  in  4+ADDR_W  instruction word: opcode [ADDR_W+3:ADDR_W], argument [ADDR_W-1:0].
- leds  out  DATA_W  output register.
- stop  out  1  core halted.
- fault  out  1  halt caused by an error.

Behaviour:
- Reset:
  - pc=0, acc=0, Z=0, C=0, sp=0 (stack empty).
  - leds=0, stop=0, fault=0, rom_req=0.
  - State is FETCH; rom_req rises on the first cycle after reset deasserts.
  - Reset asserted mid-fetch or while halted overrides everything on the next edge.
- FSM states: FETCH, EXEC, HALT.
- FETCH:
  - rom_req=1 and rom_addr=pc.
  - On a cycle with rom_ack=1: ir<=rom_data, pc<=pc+1 (mod 2^ADDR_W; 2^ADDR_W-1 wraps to 0), go to EXEC.
  - Otherwise remain in FETCH, with rom_addr stable.
  - Zero-wait ROM gives 2 cycles per instruction.
- EXEC is one cycle and always returns to FETCH, except HALT and fault cases. Let imm = arg[DATA_W-1:0].
  - 0 NOP: no effect.
  - 1 LDI: acc=imm; Z updated, C unchanged.
  - 2 ADDI: {C,acc}=acc+imm (DATA_W+1-bit sum); Z updated.
  - 3 SUBI: acc=acc-imm mod 2^DATA_W; C=1 iff borrow (acc<imm); Z updated.
  - 4 ANDI, 5 ORI, 6 XORI: bitwise; Z updated, C cleared.
  - 7 OUT: leds<=acc, visible the cycle after EXEC.
  - 8 JMP: pc=arg.
  - 9 JZ: pc=arg if Z. A JC: pc=arg if C. When not taken, pc keeps its incremented value.
  - B CALL:
    - Stack full (sp==STACK_DEPTH): fault.
    - Otherwise stack[sp]=pc (already incremented), sp+1, pc=arg.
  - C RET:
    - Stack empty: fault.
    - Otherwise sp-1, pc=stack[sp-1].
  - D HALT: go to HALT.
  - E, F: illegal, fault.
- Fault: go to HALT with fault=1; acc, flags, leds and stack are unchanged by the faulting instruction.
- HALT: stop=1, rom_req=0. Terminal until reset.
- Flags update only in EXEC of an ALU op or LDI.

Decomposition:
- Shared package / header (strike_pkg):
  - Opcode constants OP_NOP..OP_HALT.
  - FSM state encodings.
  - Field-slice helpers for opcode/argument.
- Sub-module strike_alu: combinational; inputs op, acc, imm, C; outputs result, carry, zero. Parametrised by DATA_W.
- Stack is inline in the core.

Test Plan:
- Reset/zero-wait:
  - Stimulus: ROM with 0-latency ack; program LDI 5; OUT; HALT.
  - Required: leds=4'h5 at cycle 4 after reset release; stop=1 by cycle 6; fault=0; rom_req low thereafter.
- Wait states:
  - Stimulus: same program, ack delayed 3 cycles per fetch.
  - Required: identical final leds/stop; rom_addr stable and rom_req high through every wait.
- Carry/branch:
  - Stimulus: LDI 0xF; ADDI 1; JC 0x10; OUT; at 0x10: LDI 0xA; OUT; HALT.
  - Required: acc=0, C=1, Z=1 after ADDI; branch taken; leds=4'hA.
  - Variant SUBI: LDI 2; SUBI 3 gives acc=4'hF, C=1.
- Stack:
  - Stimulus: nested CALL depth 4 then 4 RETs.
  - Required: returns to the correct addresses, no fault.
  - 5th nested CALL: stop=1, fault=1, pc frozen.
  - RET at reset state: fault=1.
- PC wrap:
  - Stimulus: NOP at 0x3F (ADDR_W=6).
  - Required: next rom_addr=0x00.
- Illegal opcode / reset mid-op:
  - Stimulus: opcode 0xE.
  - Required: stop=1, fault=1, leds unchanged.
  - Then assert reset during a pending fetch: all outputs return to reset values next edge, and fetch restarts at 0.
- Parameter sweep:
  - Stimulus: DATA_W=8, ADDR_W=8, STACK_DEPTH=2.
  - Required: ADDI 0xFF+0x01 gives acc=0x00, C=1.
